// File: rtl/uart_tx_framer.sv
// UART transmit framer: valid/ready word intake, one-deep holding register, start/data/parity/stop serializer.
// Define UART_TX_PARITY_EN to build the parity bit; without it PAR_EN and PAR_TYP are ignored.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [CW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic                  cur_stop2;
  logic                  hold_stop2;
  logic                  hold_full;

  logic accept;
  logic last_stop;
  logic can_load;
  logic take_in;
  logic take_hold;
  logic to_hold;

`ifdef UART_TX_PARITY_EN
  logic cur_par_en;
  logic cur_par_bit;
  logic hold_par_en;
  logic hold_par_bit;
  logic new_par;

  assign new_par = (^P_DATA) ^ PAR_TYP;
`else
  logic unused_par;

  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  assign Data_Ready = !hold_full;
  assign accept     = Data_Valid && !hold_full;
  assign last_stop  = (state == STOP) && (!cur_stop2 || stop_cnt);

  // The shift register can only be reloaded when idle or on the final stop cycle;
  // a pending held word always has priority over a fresh one.
  always_comb begin
    can_load  = (state == IDLE) || last_stop;
    take_hold = can_load && hold_full;
    take_in   = can_load && accept && !hold_full;
    to_hold   = accept && !can_load;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      shift      <= '0;
      hold_data  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      cur_stop2  <= 1'b0;
      hold_stop2 <= 1'b0;
      hold_full  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      cur_par_en   <= 1'b0;
      cur_par_bit  <= 1'b0;
      hold_par_en  <= 1'b0;
      hold_par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          if (take_in || take_hold) state <= START;
        end
        START: begin
          TX_OUT <= 1'b0;
          state  <= DATA;
        end
        DATA: begin
          TX_OUT <= shift[0];
          shift  <= shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            state   <= cur_par_en ? PARITY : STOP;
`else
            state   <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          TX_OUT <= cur_par_bit;
          state  <= STOP;
        end
`endif
        STOP: begin
          TX_OUT <= 1'b1;
          if (last_stop) begin
            stop_cnt <= 1'b0;
            if (take_in || take_hold) begin
              state <= START;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          TX_OUT <= 1'b1;
          state  <= IDLE;
        end
      endcase

      // Frame settings travel with the word so later input changes never touch it.
      if (take_in) begin
        shift     <= P_DATA;
        cur_stop2 <= STOP2;
        busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
        cur_par_en  <= PAR_EN;
        cur_par_bit <= new_par;
`endif
      end

      if (take_hold) begin
        shift     <= hold_data;
        cur_stop2 <= hold_stop2;
        hold_full <= 1'b0;
        busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
        cur_par_en  <= hold_par_en;
        cur_par_bit <= hold_par_bit;
`endif
      end

      if (to_hold) begin
        hold_data  <= P_DATA;
        hold_stop2 <= STOP2;
        hold_full  <= 1'b1;
        busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
        hold_par_en  <= PAR_EN;
        hold_par_bit <= new_par;
`endif
      end
    end
  end

endmodule
